// File: rtl/gpu_raster_pkg.sv
// Shared types and helpers for the bitplane raster fetch path: colour modes,
// pixels-per-fetch lookup and the fetch sequencer state encoding.
package gpu_raster_pkg;

  localparam logic [1:0] CM_1BPP = 2'd0;
  localparam logic [1:0] CM_2BPP = 2'd1;
  localparam logic [1:0] CM_4BPP = 2'd2;
  localparam logic [1:0] CM_8BPP = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    FETCH     = 2'd2,
    LINE_DONE = 2'd3
  } fetch_state_e;

  // Pixels covered by one fetch unit (one byte, or one byte pair in two-byte mode)
  function automatic logic [3:0] ppf_of(input logic [1:0] mode);
    case (mode)
      CM_1BPP: ppf_of = 4'd8;
      CM_2BPP: ppf_of = 4'd4;
      CM_4BPP: ppf_of = 4'd2;
      default: ppf_of = 4'd1;
    endcase
  endfunction

  // Two-byte fetch only has a meaning for colour text (1bpp) and 16bpp (8bpp slot)
  function automatic logic mode_illegal(input logic two_byte, input logic [1:0] mode);
    mode_illegal = two_byte && (mode == CM_2BPP || mode == CM_4BPP);
  endfunction

endpackage

// File: rtl/fetch_addr_counter.sv
// Line pointer / fetch address / sub-pixel counter for one bitplane layer.
// All address arithmetic wraps modulo 2^ADDR_W.
module fetch_addr_counter
  import gpu_raster_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int STRIDE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_base,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                start_line,
  input  logic                advance,
  input  logic                pixel,
  input  logic [STRIDE_W-1:0] stride,
  input  logic                two_byte,
  input  logic [3:0]          ppf,
  output logic [ADDR_W-1:0]   fetch_addr,
  output logic                sub_zero
);

  logic [ADDR_W-1:0] line_ptr;
  logic [ADDR_W-1:0] line_ptr_nxt;
  logic [ADDR_W-1:0] step;
  logic [2:0]        sub;
  logic              sub_last;

  // A new frame base wins over a line advance landing on the same tick
  always_comb begin
    line_ptr_nxt = line_ptr;
    if (load_base)
      line_ptr_nxt = base_addr;
    else if (advance)
      line_ptr_nxt = line_ptr + ADDR_W'(stride);
  end

  assign step     = two_byte ? ADDR_W'(2) : ADDR_W'(1);
  assign sub_zero = (sub == 3'd0);
  assign sub_last = (sub == 3'(ppf - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_ptr   <= '0;
      fetch_addr <= '0;
      sub        <= '0;
    end else begin
      line_ptr <= line_ptr_nxt;
      if (start_line) begin
        fetch_addr <= line_ptr_nxt;
        sub        <= '0;
      end else if (pixel) begin
        if (sub_zero)
          fetch_addr <= fetch_addr + step;
        sub <= sub_last ? 3'd0 : sub + 3'd1;
      end
    end
  end

endmodule

// File: rtl/bitplane_fetch_sequencer.sv
// Per-layer GPU RAM read sequencer: sync timing + frame-shadowed config -> read strobes.
// Optional FETCH_VSCALE_EN: repeat each bitmap line (v_scale+1) times.
module bitplane_fetch_sequencer
  import gpu_raster_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int STRIDE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          pc_ena,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic                h_active,
  input  logic                v_active,
  input  logic                layer_ena,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [STRIDE_W-1:0] line_bytes,
  input  logic [1:0]          colour_mode_in,
  input  logic                two_byte_in,
  input  logic [1:0]          v_scale,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_rd,
  output logic [9:0]          x_out,
  output logic [1:0]          colour_mode_out,
  output logic                two_byte_out,
  output logic                cfg_err
);

  fetch_state_e        state, st_f;
  logic                tick, load_base, line_evt, line_begin, line_abort;
  logic                line_done, pixel, advance, sub_zero;
  logic [1:0]          mode_sh;
  logic                two_byte_sh, cfg_err_sh;
  logic [STRIDE_W-1:0] stride_sh;
  logic [3:0]          ppf_cur;
  logic [9:0]          x;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [ADDR_W-1:0]   ram_addr_p1;
  logic [9:0]          x_p1;
  logic                vld_p1;

  // Frame strobe is resolved first so a coincident line_start sees the new frame
  always_comb begin
    tick      = (pc_ena == 4'd0);
    load_base = tick && frame_start;
    st_f      = state;
    if (load_base)
      st_f = layer_ena ? WAIT_LINE : IDLE;
    line_evt   = tick && line_start && (st_f != IDLE);
    line_begin = line_evt && v_active;
    line_abort = line_evt && !v_active;
    line_done  = tick && !load_base && (state == FETCH) && (line_start || !h_active);
    pixel      = tick && !load_base && (state == FETCH) && !line_start && h_active;
  end

  assign ppf_cur = ppf_of(mode_sh);

`ifdef FETCH_VSCALE_EN
  logic [1:0] vscale_sh;
  logic [1:0] rep_cnt;

  assign advance = line_done && (rep_cnt == vscale_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vscale_sh <= '0;
      rep_cnt   <= '0;
    end else if (load_base) begin
      vscale_sh <= v_scale;
      rep_cnt   <= '0;
    end else if (line_done) begin
      rep_cnt <= advance ? 2'd0 : rep_cnt + 2'd1;
    end
  end
`else
  logic unused_vscale;
  assign unused_vscale = ^v_scale;
  assign advance       = line_done;
`endif

  fetch_addr_counter #(
    .ADDR_W   (ADDR_W),
    .STRIDE_W (STRIDE_W)
  ) u_fetch_addr_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_base  (load_base),
    .base_addr  (base_addr),
    .start_line (line_begin),
    .advance    (advance),
    .pixel      (pixel),
    .stride     (stride_sh),
    .two_byte   (two_byte_sh),
    .ppf        (ppf_cur),
    .fetch_addr (fetch_addr),
    .sub_zero   (sub_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_sh     <= '0;
      two_byte_sh <= 1'b0;
      cfg_err_sh  <= 1'b0;
      stride_sh   <= '0;
      x           <= '0;
      vld_p1      <= 1'b0;
      ram_addr_p1 <= '0;
      x_p1        <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (load_base) begin
        mode_sh     <= colour_mode_in;
        two_byte_sh <= two_byte_in;
        cfg_err_sh  <= mode_illegal(two_byte_in, colour_mode_in);
        stride_sh   <= line_bytes;
      end
      if (line_abort)
        state <= IDLE;
      else if (line_begin)
        state <= FETCH;
      else if (load_base)
        state <= st_f;
      else if (tick) begin
        case (state)
          FETCH:     if (!h_active) state <= LINE_DONE;
          LINE_DONE: state <= WAIT_LINE;
          default:   ;
        endcase
      end
      if (line_begin)
        x <= '0;
      else if (pixel)
        x <= x + 10'd1;
      // p1: read request registered one clk after its pixel tick
      if (pixel) begin
        x_p1 <= x;
        if (sub_zero && !cfg_err_sh) begin
          vld_p1      <= 1'b1;
          ram_addr_p1 <= fetch_addr;
        end
      end
    end
  end

  assign ram_addr        = ram_addr_p1;
  assign ram_rd          = vld_p1;
  assign x_out           = x_p1;
  assign colour_mode_out = mode_sh;
  assign two_byte_out    = two_byte_sh;
  assign cfg_err         = cfg_err_sh;

endmodule

// File: tb/tb_bitplane_fetch_sequencer.sv
// Scoreboard bench for bitplane_fetch_sequencer: directed frames/lines, expected reads queued
// by the stimulus and popped by a monitor on every ram_rd pulse.
module tb_bitplane_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pc_ena;
  logic        frame_start, line_start, h_active, v_active, layer_ena;
  logic [19:0] base_addr;
  logic [15:0] line_bytes;
  logic [1:0]  colour_mode_in;
  logic        two_byte_in;
  logic [1:0]  v_scale;
  logic [19:0] ram_addr;
  logic        ram_rd;
  logic [9:0]  x_out;
  logic [1:0]  colour_mode_out;
  logic        two_byte_out;
  logic        cfg_err;

  typedef struct packed {
    logic [19:0] addr;
    logic [9:0]  x;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bitplane_fetch_sequencer #(.ADDR_W(20), .STRIDE_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_ena          (pc_ena),
    .frame_start     (frame_start),
    .line_start      (line_start),
    .h_active        (h_active),
    .v_active        (v_active),
    .layer_ena       (layer_ena),
    .base_addr       (base_addr),
    .line_bytes      (line_bytes),
    .colour_mode_in  (colour_mode_in),
    .two_byte_in     (two_byte_in),
    .v_scale         (v_scale),
    .ram_addr        (ram_addr),
    .ram_rd          (ram_rd),
    .x_out           (x_out),
    .colour_mode_out (colour_mode_out),
    .two_byte_out    (two_byte_out),
    .cfg_err         (cfg_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ram_rd === 1'b1) begin : mon
      exp_t e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got addr 0x%0h x %0d, expected no read", ram_addr, x_out);
      end else begin
        e = exp_q.pop_front();
        check("rd_addr", 32'(ram_addr), 32'(e.addr));
        check("rd_x", 32'(x_out), 32'(e.x));
      end
    end
  end

  // One pixel tick: pc_ena==0 for a single clk, then one non-tick clk
  task automatic tick(input bit fs, input bit ls, input bit ha, input bit va);
    @(negedge clk);
    frame_start = fs;
    line_start  = ls;
    h_active    = ha;
    v_active    = va;
    pc_ena      = 4'd0;
    @(negedge clk);
    pc_ena      = 4'd1;
    frame_start = 1'b0;
    line_start  = 1'b0;
  endtask

  task automatic run_line(input bit fs, input int npx, input logic [19:0] a0, input int ppf,
                          input int step, input bit rd_exp, input bit x_exp, input bit close);
    logic [19:0] a;
    a = a0;
    tick(fs, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < npx; i++) begin
      if (rd_exp && (i % ppf == 0)) begin
        exp_q.push_back('{addr: a, x: 10'(i)});
        a = a + 20'(step);
      end
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      if (x_exp) check("x_out", 32'(x_out), 32'(i));
    end
    if (close) tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pc_ena = 4'd1;
    frame_start = 1'b0; line_start = 1'b0; h_active = 1'b0; v_active = 1'b0;
    layer_ena = 1'b0; base_addr = '0; line_bytes = '0;
    colour_mode_in = 2'd0; two_byte_in = 1'b0; v_scale = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_ram_rd", 32'(ram_rd), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_x_out", 32'(x_out), 0);
    check("rst_mode", 32'(colour_mode_out), 0);
    check("rst_two_byte", 32'(two_byte_out), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    rst_n = 1'b1;

    // 1bpp byte fetch: two reads per 16 px, second line one stride on
    layer_ena = 1'b1; base_addr = 20'h00100; line_bytes = 16'd40;
    colour_mode_in = 2'd0; two_byte_in = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("m0_mode", 32'(colour_mode_out), 0);
    check("m0_cfg_err", 32'(cfg_err), 0);
    run_line(1'b0, 16, 20'h00100, 8, 1, 1'b1, 1'b1, 1'b1);
    run_line(1'b0, 16, 20'h00128, 8, 1, 1'b1, 1'b1, 1'b1);

    // 16bpp two-byte fetch across the top of the address space
    base_addr = 20'hFFFFE; colour_mode_in = 2'd3; two_byte_in = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("m3_mode", 32'(colour_mode_out), 3);
    check("m3_two_byte", 32'(two_byte_out), 1);
    check("m3_cfg_err", 32'(cfg_err), 0);
    run_line(1'b0, 3, 20'hFFFFE, 1, 2, 1'b1, 1'b1, 1'b1);

    // Illegal two-byte + 4bpp: no reads, x still counts
    base_addr = 20'h00040; colour_mode_in = 2'd2; two_byte_in = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("bad_cfg_err", 32'(cfg_err), 1);
    run_line(1'b0, 8, 20'h0, 1, 1, 1'b0, 1'b1, 1'b1);

    // frame+line together use the new base; mid-frame config edits are ignored
    base_addr = 20'h00200; line_bytes = 16'd16; colour_mode_in = 2'd0; two_byte_in = 1'b0;
    run_line(1'b1, 8, 20'h00200, 8, 1, 1'b1, 1'b1, 1'b1);
    check("mid_cfg_err", 32'(cfg_err), 0);
    base_addr = 20'h00300; line_bytes = 16'h0999;
    run_line(1'b0, 8, 20'h00210, 8, 1, 1'b1, 1'b1, 1'b1);
    run_line(1'b1, 8, 20'h00300, 8, 1, 1'b1, 1'b1, 1'b1);

    // line_start arriving while still fetching closes the line and starts the next
    base_addr = 20'h00500; line_bytes = 16'h0020; colour_mode_in = 2'd1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    run_line(1'b0, 4, 20'h00500, 4, 1, 1'b1, 1'b1, 1'b0);
    run_line(1'b0, 4, 20'h00520, 4, 1, 1'b1, 1'b1, 1'b1);

    // line_start with v_active low drops to IDLE; later lines do nothing
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    run_line(1'b0, 4, 20'h0, 1, 1, 1'b0, 1'b0, 1'b1);
    check("idle_x_hold", 32'(x_out), 3);

    // Vertical repeat (ignored without FETCH_VSCALE_EN)
    base_addr = 20'h01000; line_bytes = 16'd80; colour_mode_in = 2'd3; two_byte_in = 1'b0;
    v_scale = 2'd1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_VSCALE_EN
    run_line(1'b0, 2, 20'h01000, 1, 1, 1'b1, 1'b1, 1'b1);
    run_line(1'b0, 2, 20'h01000, 1, 1, 1'b1, 1'b1, 1'b1);
    run_line(1'b0, 2, 20'h01050, 1, 1, 1'b1, 1'b1, 1'b1);
    run_line(1'b0, 2, 20'h01050, 1, 1, 1'b1, 1'b1, 1'b1);
`else
    run_line(1'b0, 2, 20'h01000, 1, 1, 1'b1, 1'b1, 1'b1);
    run_line(1'b0, 2, 20'h01050, 1, 1, 1'b1, 1'b1, 1'b1);
    run_line(1'b0, 2, 20'h010A0, 1, 1, 1'b1, 1'b1, 1'b1);
    run_line(1'b0, 2, 20'h010F0, 1, 1, 1'b1, 1'b1, 1'b1);
`endif
    v_scale = 2'd0;

    // Async reset while a read strobe is high
    base_addr = 20'h00700; line_bytes = 16'd8; colour_mode_in = 2'd3;
    run_line(1'b1, 1, 20'h00700, 1, 1, 1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ram_rd", 32'(ram_rd), 0);
    check("arst_ram_addr", 32'(ram_addr), 0);
    check("arst_x_out", 32'(x_out), 0);
    check("arst_mode", 32'(colour_mode_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_line(1'b0, 8, 20'h0, 1, 1, 1'b0, 1'b0, 1'b1);
    check("post_rst_x", 32'(x_out), 0);
    check("post_rst_ram_addr", 32'(ram_addr), 0);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
